// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: accepts tagged FPU commands, queues them in a small FIFO and
// issues them one at a time to top_FPU. Each operand set is held stable for
// the FPU latency, then the result is captured, classified and returned on a
// valid/ready response port.
module fpu_issue_ctrl #(
    parameter int FPU_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       fpu_operation,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic [31:0]      fpu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(FPU_LATENCY + 1);

    typedef struct packed {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ready_en;
    logic             full;
    logic             push;
    logic             pop;
    cmd_t             head;

    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic [TAG_W-1:0] issue_tag;
    logic [3:0]       flags_next;

    // ready_en keeps cmd_ready low until the first edge after reset release;
    // a full FIFO refuses pushes even when a pop lands on the same edge.
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign cmd_ready = ready_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);

    // Command storage: written on push, read combinationally at the head.
    // NOTE: payload RAM has no reset; only pointers/count need defined values,
    // which keeps it mappable to plain flops or a RAM without reset muxes.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Result classification from the word on fpu_out and the issued operands.
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        flags_next    = '0;
        flags_next[0] = (fpu_out[30:23] == 8'h00) && (fpu_out[22:0] == 23'd0);
        flags_next[1] = (fpu_out[30:23] == 8'hFF) && (fpu_out[22:0] == 23'd0);
        flags_next[2] = (fpu_out[30:23] == 8'hFF) && (fpu_out[22:0] != 23'd0);
        flags_next[3] = (fpu_operation == 2'b11) && (fpu_b[30:0] == 31'd0);
    end

    // Issue FSM: launch from IDLE, count down the FPU latency, hold the
    // response until it is taken, then return to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            issue_tag     <= '0;
            fpu_operation <= '0;
            fpu_a         <= '0;
            fpu_b         <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_tag       <= '0;
            rsp_flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        fpu_operation <= head.op;
                        fpu_a         <= head.a;
                        fpu_b         <= head.b;
                        issue_tag     <= head.tag;
                        cnt           <= LAT_W'(FPU_LATENCY);
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LAT_W'(1);
                    end else begin
                        rsp_data  <= fpu_out;
                        rsp_tag   <= issue_tag;
                        rsp_flags <= flags_next;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: a behavioural top_FPU stand-in,
// directed timing sequences, a vector table and a randomized scoreboard run.
module tb_fpu_issue_ctrl;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared command inputs; each DUT has its own valid/ready/reset.
    logic             cmd_valid, d3_cmd_valid;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_a, cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic             rst, d3_rst;
    logic             rsp_ready, d3_rsp_ready;

    logic             cmd_ready, rsp_valid, busy;
    logic [1:0]       fpu_operation;
    logic [31:0]      fpu_a, fpu_b, fpu_out, rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic [3:0]       rsp_flags;

    logic             d3_cmd_ready, d3_rsp_valid, d3_busy;
    logic [1:0]       d3_fpu_operation;
    logic [31:0]      d3_fpu_a, d3_fpu_b, d3_fpu_out, d3_rsp_data;
    logic [TAG_W-1:0] d3_rsp_tag;
    logic [3:0]       d3_rsp_flags;

    fpu_issue_ctrl #(.FPU_LATENCY(1), .FIFO_DEPTH(4), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_out(fpu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_flags(rsp_flags), .busy(busy)
    );

    fpu_issue_ctrl #(.FPU_LATENCY(3), .FIFO_DEPTH(4), .TAG_W(TAG_W)) u_dut3 (
        .clk(clk), .rst(d3_rst),
        .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .fpu_operation(d3_fpu_operation), .fpu_a(d3_fpu_a), .fpu_b(d3_fpu_b), .fpu_out(d3_fpu_out),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_data(d3_rsp_data),
        .rsp_tag(d3_rsp_tag), .rsp_flags(d3_rsp_flags), .busy(d3_busy)
    );

    // top_FPU stand-in: known IEEE results for the directed operands,
    // otherwise a pass-through (a for add/mul, b for sub/div) so special
    // encodings reach the output.
    function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00 && a == 32'hC1C80000 && b == 32'h41880000) return 32'hC1000000;
        if (op == 2'b10 && a == 32'h41A00000 && b == 32'h40000000) return 32'h42200000;
        if (op == 2'b01 && a == 32'h41900000 && b == 32'h40400000) return 32'h41700000;
        if (op == 2'b11 && a == 32'h41A00000 && b == 32'h40900000) return 32'h408E38E4;
        if (op == 2'b11 && a == 32'h41A00000 && b == 32'h80000000) return 32'hFF800000;
        return op[0] ? b : a;
    endfunction

    // Output appears exactly FPU_LATENCY edges after the operands change.
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= fpu_fn(fpu_operation, fpu_a, fpu_b);
        pipe3[0] <= fpu_fn(d3_fpu_operation, d3_fpu_a, d3_fpu_b);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign fpu_out    = pipe1;
    assign d3_fpu_out = pipe3[2];

    // Flag classification straight from the IEEE-754 field definitions.
    function automatic logic [3:0] ref_flags(input logic [31:0] r, input logic [1:0] op, input logic [31:0] b);
        logic [7:0]  e;
        logic [22:0] m;
        logic        b_is_zero;
        e = r[30:23];
        m = r[22:0];
        b_is_zero = (b == 32'h00000000) || (b == 32'h80000000);
        return {(op == 2'b11) && b_is_zero, (e == 8'hFF) && (m != 0), (e == 8'hFF) && (m == 0), (e == 0) && (m == 0)};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00001;
            5: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one command from a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int k = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, report the response, pass the handshake edge.
    task automatic wait_rsp(output logic [31:0] d, output logic [TAG_W-1:0] t, output logic [3:0] f);
        int k = 0;
        while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
        check("rsp_valid_wait", 64'(rsp_valid), 64'd1);
        d = rsp_data; t = rsp_tag; f = rsp_flags;
        @(negedge clk);
    endtask

    // Launch monitor: records the cycle whenever the issued operand set changes.
    bit          mon_en = 1'b0;
    int          launch_q[$];
    logic [65:0] last_fpu;
    always @(negedge clk) begin
        if (mon_en && ({fpu_operation, fpu_a, fpu_b} != last_fpu)) launch_q.push_back(cyc);
        last_fpu <= {fpu_operation, fpu_a, fpu_b};
    end

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_d;
        logic [3:0]       exp_f;
    } vec_t;

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] tag;
        logic [3:0]       f;
    } exp_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs [11];
        exp_t             exp_q[$];
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        logic [3:0]       f;
        int               acc;
        bit               take, stable, seen;
        logic [31:0]      s_d, s_a, s_b;
        logic [TAG_W-1:0] s_t;
        logic [3:0]       s_f;
        logic [1:0]       s_op;
        logic [31:0]      r;
        int               max_out;

        vecs[0]  = '{2'b10, 32'h41A00000, 32'h40000000, 4'd1, 32'h42200000, 4'b0000};
        vecs[1]  = '{2'b01, 32'h41900000, 32'h40400000, 4'd2, 32'h41700000, 4'b0000};
        vecs[2]  = '{2'b11, 32'h41A00000, 32'h40900000, 4'd3, 32'h408E38E4, 4'b0000};
        vecs[3]  = '{2'b11, 32'h41A00000, 32'h80000000, 4'd4, 32'hFF800000, 4'b1010};
        vecs[4]  = '{2'b11, 32'h3F800000, 32'h00000000, 4'd5, 32'h00000000, 4'b1001};
        vecs[5]  = '{2'b11, 32'h3F800000, 32'h00000001, 4'd6, 32'h00000001, 4'b0000};
        vecs[6]  = '{2'b00, 32'h7FC00000, 32'h3F800000, 4'd7, 32'h7FC00000, 4'b0100};
        vecs[7]  = '{2'b10, 32'hFF800000, 32'h3F800000, 4'd8, 32'hFF800000, 4'b0010};
        vecs[8]  = '{2'b01, 32'h3F800000, 32'h80000000, 4'd9, 32'h80000000, 4'b0001};
        vecs[9]  = '{2'b00, 32'h7F7FFFFF, 32'h00000000, 4'd10, 32'h7F7FFFFF, 4'b0000};
        vecs[10] = '{2'b10, 32'h7F800001, 32'h00000000, 4'd15, 32'h7F800001, 4'b0100};

        rst = 1'b0; d3_rst = 1'b0;
        cmd_valid = 1'b0; d3_cmd_valid = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        rsp_ready = 1'b0; d3_rsp_ready = 1'b0;

        // Reset state.
        @(negedge clk); @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_fpu", 64'({fpu_operation, fpu_a}), 64'd0);
        check("rst_fpu_b", 64'(fpu_b), 64'd0);
        check("rst_rsp", 64'({rsp_data, rsp_tag, rsp_flags}), 64'd0);
        check("rst3_rsp", 64'({d3_rsp_data, d3_rsp_tag, d3_rsp_flags}), 64'd0);
        rst = 1'b1; d3_rst = 1'b1;
        #1;
        check("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);

        // Add, latency and launch timing (FPU_LATENCY = 1).
        send(2'b00, 32'hC1C80000, 32'h41880000, 4'd3);
        check("add_rsp_early0", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("add_fpu_a", 64'(fpu_a), 64'hC1C80000);
        check("add_fpu_b", 64'(fpu_b), 64'h41880000);
        check("add_fpu_op", 64'(fpu_operation), 64'd0);
        check("add_rsp_early1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("add_rsp_early2", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("add_rsp_valid", 64'(rsp_valid), 64'd1);
        check("add_rsp", 64'({rsp_data, rsp_tag, rsp_flags}), {24'd0, 32'hC1000000, 4'd3, 4'b0000});
        rsp_ready = 1'b1;
        @(negedge clk);
        check("add_rsp_done", 64'(rsp_valid), 64'd0);
        check("add_fpu_kept", 64'(fpu_a), 64'hC1C80000);

        // Vector table, one command at a time.
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_rsp(d, t, f);
            check($sformatf("vec%0d_rsp", i), 64'({d, t, f}), 64'({vecs[i].exp_d, vecs[i].tag, vecs[i].exp_f}));
        end

        // In-order stream with launch spacing.
        launch_q.delete();
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    wait_rsp(d, t, f);
                    check($sformatf("stream%0d_rsp", i), 64'({d, t}), 64'({vecs[i].exp_d, vecs[i].tag}));
                end
            end
        join
        mon_en = 1'b0;
        check("stream_launches", 64'(launch_q.size()), 64'd3);
        for (int i = 1; i < launch_q.size(); i++)
            check($sformatf("stream_spacing%0d", i), 64'(launch_q[i] - launch_q[i-1] >= 4), 64'd1);

        // Full FIFO with the response stalled: 4 queued + 1 in flight.
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 30 && acc < 7; c++) begin
            cmd_op = 2'b00; cmd_a = 32'h3F800000 + 32'(acc); cmd_b = 32'h40000000;
            cmd_tag = TAG_W'(5 + acc); cmd_valid = 1'b1;
            take = cmd_ready;
            @(negedge clk);
            if (take) acc++;
        end
        cmd_valid = 1'b0;
        check("full_accepted", 64'(acc), 64'd5);
        check("full_cmd_ready", 64'(cmd_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(d, t, f);
            check($sformatf("drain%0d_rsp", i), 64'({d, t}), 64'({32'h3F800000 + 32'(i), TAG_W'(5 + i)}));
        end
        @(negedge clk);
        check("drain_cmd_ready", 64'(cmd_ready), 64'd1);
        check("drain_busy", 64'(busy), 64'd0);

        // Backpressure in RESP with a second command waiting in the FIFO.
        rsp_ready = 1'b0;
        send(2'b11, 32'h41A00000, 32'h80000000, 4'd10);
        send(2'b10, 32'h41A00000, 32'h40000000, 4'd11);
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        s_d = rsp_data; s_t = rsp_tag; s_f = rsp_flags;
        s_op = fpu_operation; s_a = fpu_a; s_b = fpu_b;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data != s_d || rsp_tag != s_t || rsp_flags != s_f) stable = 1'b0;
            if (fpu_operation != s_op || fpu_a != s_a || fpu_b != s_b) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_held_rsp", 64'({s_d, s_t, s_f}), {24'd0, 32'hFF800000, 4'd10, 4'b1010});
        check("bp_no_pop", 64'(s_a), 64'h41A00000);
        rsp_ready = 1'b1;
        wait_rsp(d, t, f);
        check("bp_first", 64'({d, t, f}), {24'd0, 32'hFF800000, 4'd10, 4'b1010});
        wait_rsp(d, t, f);
        check("bp_second", 64'({d, t, f}), {24'd0, 32'h42200000, 4'd11, 4'b0000});

        // Reset during WAIT on the FPU_LATENCY = 3 instance.
        d3_rsp_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            cmd_op = 2'b00; cmd_a = 32'h40000000 + 32'(acc); cmd_b = 32'h3F800000;
            cmd_tag = TAG_W'(acc); d3_cmd_valid = 1'b1;
            take = d3_cmd_ready;
            @(negedge clk);
            if (take) acc++;
        end
        d3_cmd_valid = 1'b0;
        check("d3_accepted", 64'(acc), 64'd3);
        check("d3_busy_wait", 64'(d3_busy), 64'd1);
        check("d3_launched", 64'(d3_fpu_a), 64'h40000000);
        check("d3_no_rsp_yet", 64'(d3_rsp_valid), 64'd0);
        #2 d3_rst = 1'b0;
        #1;
        check("d3_rst_rsp_valid", 64'(d3_rsp_valid), 64'd0);
        check("d3_rst_busy", 64'(d3_busy), 64'd0);
        check("d3_rst_fpu", 64'({d3_fpu_operation, d3_fpu_a}), 64'd0);
        check("d3_rst_fpu_b", 64'(d3_fpu_b), 64'd0);
        check("d3_rst_cmd_ready", 64'(d3_cmd_ready), 64'd0);
        @(negedge clk);
        d3_rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d3_rsp_valid || d3_fpu_a != 32'd0) seen = 1'b1;
        end
        check("d3_flushed", 64'(seen), 64'd0);
        check("d3_cmd_ready_after", 64'(d3_cmd_ready), 64'd1);
        check("d3_idle_after", 64'(d3_busy), 64'd0);

        // Randomized traffic against an in-order scoreboard.
        max_out = 0;
        for (int c = 0; c < 700; c++) begin
            if (c < 600) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_a     = pick();
                cmd_b     = pick();
                cmd_tag   = TAG_W'($urandom);
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else begin
                cmd_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                r = fpu_fn(cmd_op, cmd_a, cmd_b);
                exp_q.push_back('{r, cmd_tag, ref_flags(r, cmd_op, cmd_b)});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rnd_rsp", 64'({rsp_data, rsp_tag, rsp_flags}), 64'({e.d, e.tag, e.f}));
                end
            end
            if (exp_q.size() > max_out) max_out = exp_q.size();
            @(negedge clk);
        end
        check("rnd_drained", 64'(exp_q.size()), 64'd0);
        check("rnd_capacity", 64'(max_out <= 5), 64'd1);
        check("rnd_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
